// File: rtl/trace_packer.sv
// trace_packer: discards filtered instructions, tags kept ones with a skip count, buffers them in a FWFT FIFO.
// Optional feature: define TRACE_PACKER_TIMESTAMP_EN to add a 32-bit push-cycle timestamp as the top field.
module trace_packer #(
    parameter int DEPTH      = 16,
    parameter int PC_WIDTH   = 64,
    parameter int SKIP_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [PC_WIDTH-1:0]           in_pc,
    input  logic [31:0]                   in_instr,
    input  logic                          drop_instr,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef TRACE_PACKER_TIMESTAMP_EN
    output logic [PC_WIDTH+SKIP_WIDTH+63:0] out_data,
`else
    output logic [PC_WIDTH+SKIP_WIDTH+31:0] out_data,
`endif
    output logic                          overflow,
    output logic [15:0]                   lost_count,
    input  logic                          overflow_clr,
    output logic [$clog2(DEPTH):0]        level
);
    localparam int AW = $clog2(DEPTH);
`ifdef TRACE_PACKER_TIMESTAMP_EN
    localparam int DW = PC_WIDTH + SKIP_WIDTH + 64;
`else
    localparam int DW = PC_WIDTH + SKIP_WIDTH + 32;
`endif
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [DW-1:0]         r_mem [DEPTH];
    logic [AW-1:0]         r_wp;
    logic [AW-1:0]         r_rp;
    logic [AW:0]           r_level;
    logic [SKIP_WIDTH-1:0] r_skip;
    logic                  r_overflow;
    logic [15:0]           r_lost;
    logic                  w_kept;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_lose;
    logic [DW-1:0]         w_item;

    assign w_kept = in_valid & ~drop_instr;
    assign w_drop = in_valid & drop_instr;
    assign w_pop  = out_valid & out_ready;
    assign w_push = w_kept & ((r_level != FULL) | w_pop);
    assign w_lose = w_kept & ~w_push;

`ifdef TRACE_PACKER_TIMESTAMP_EN
    logic [31:0] r_ts;
    // free-running cycle counter sampled into each pushed item
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ts <= '0;
        else     r_ts <= r_ts + 32'd1;
    end
    assign w_item = {r_ts, r_skip, in_instr, in_pc};
`else
    assign w_item = {r_skip, in_instr, in_pc};
`endif

    assign out_valid  = r_level != '0;
    assign out_data   = out_valid ? r_mem[r_rp] : '0;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign lost_count = r_lost;

    // storage array; contents are masked by out_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= w_item;
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_level <= r_level + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end

    // dropped-instruction counter: saturates, cleared by every kept item even if it is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_skip <= '0;
        else if (w_kept)                  r_skip <= '0;
        else if (w_drop && r_skip != '1)  r_skip <= r_skip + 1'b1;
    end

    // loss tracking; a new loss takes priority over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_lost     <= '0;
        end else if (w_lose) begin
            r_overflow <= 1'b1;
            r_lost     <= overflow_clr ? 16'd1 : (r_lost != 16'hFFFF ? r_lost + 16'd1 : r_lost);
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
            r_lost     <= '0;
        end
    end
endmodule

// File: tb/tb_trace_packer.sv
// tb_trace_packer: scoreboard bench for trace_packer (DEPTH=16, PC_WIDTH=64, SKIP_WIDTH=4).
module tb_trace_packer;
    localparam int PW = 64;
    localparam int SW = 4;
`ifdef TRACE_PACKER_TIMESTAMP_EN
    localparam int DW = PW + SW + 64;
`else
    localparam int DW = PW + SW + 32;
`endif

    logic          clk = 0;
    logic          rst = 1;
    logic          in_valid = 0;
    logic [PW-1:0] in_pc = '0;
    logic [31:0]   in_instr = '0;
    logic          drop_instr = 0;
    logic          out_valid;
    logic          out_ready = 1;
    logic [DW-1:0] out_data;
    logic          overflow;
    logic [15:0]   lost_count;
    logic          overflow_clr = 0;
    logic [4:0]    level;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_q[$];
    logic [SW-1:0] m_skip = '0;
    int            m_lost = 0;
    logic          m_ovf = 0;
    logic [31:0]   m_ts = '0;

    trace_packer #(.DEPTH(16), .PC_WIDTH(PW), .SKIP_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .drop_instr(drop_instr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .lost_count(lost_count), .overflow_clr(overflow_clr), .level(level)
    );

    always #5 clk = ~clk;

    // scoreboard: compare committed state, then advance the model by the coming edge
    always @(negedge clk) begin
        logic pop, kept, full;
        logic [DW-1:0] item;
        if (rst) begin
            m_q.delete();
            m_skip = '0;
            m_lost = 0;
            m_ovf  = 0;
            m_ts   = '0;
        end
        checks++;
        if (out_valid !== (m_q.size() != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_q.size() != 0);
        end
        checks++;
        if (m_q.size() != 0) begin
            if (out_data !== m_q[0]) begin
                errors++;
                $display("FAIL head_data: got %h expected %h", out_data, m_q[0]);
            end
        end else if (out_data !== '0) begin
            errors++;
            $display("FAIL empty_data: got %h expected 0", out_data);
        end
        checks++;
        if (level !== 5'(m_q.size())) begin
            errors++;
            $display("FAIL level: got %0d expected %0d", level, m_q.size());
        end
        checks++;
        if (overflow !== m_ovf || lost_count !== 16'(m_lost)) begin
            errors++;
            $display("FAIL overflow_lost: got %b/%0d expected %b/%0d", overflow, lost_count, m_ovf, m_lost);
        end
        if (!rst) begin
            full = m_q.size() == 16;
            pop  = m_q.size() != 0 && out_ready;
            kept = in_valid && !drop_instr;
`ifdef TRACE_PACKER_TIMESTAMP_EN
            item = {m_ts, m_skip, in_instr, in_pc};
`else
            item = {m_skip, in_instr, in_pc};
`endif
            if (pop) void'(m_q.pop_front());
            if (kept) begin
                if (!full || pop) m_q.push_back(item);
                else begin
                    m_ovf  = 1;
                    m_lost = overflow_clr ? 1 : (m_lost < 65535 ? m_lost + 1 : m_lost);
                end
                m_skip = '0;
            end else begin
                if (in_valid && drop_instr && m_skip != '1) m_skip = m_skip + 1'b1;
                if (overflow_clr) begin
                    m_ovf  = 0;
                    m_lost = 0;
                end
            end
            m_ts = m_ts + 32'd1;
        end
    end

    task automatic drive(input logic v, input logic d, input logic [PW-1:0] pc, input logic [31:0] ins);
        @(posedge clk);
        #1;
        in_valid   = v;
        drop_instr = d;
        in_pc      = pc;
        in_instr   = ins;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, '0, '0);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0 || lost_count !== 16'd0) begin
            errors++;
            $display("FAIL reset: got v=%b lvl=%0d ovf=%b lost=%0d expected all 0", out_valid, level, overflow, lost_count);
        end
        drive(0, 0, '0, '0);
        rst = 0;
        idle(2);
    endtask

    task automatic test_mixed;
        out_ready = 1;
        repeat (3) drive(1, 1, 64'h100, 32'h13);
        drive(1, 0, 64'h80000010, 32'h00000063);
        drive(1, 0, 64'h80000014, 32'h0000006f);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data[99:96] !== 4'd3 || out_data[95:64] !== 32'h63 || out_data[63:0] !== 64'h80000010) begin
            errors++;
            $display("FAIL mixed_first: got v=%b skip=%0d instr=%h pc=%h expected 1/3/63/80000010",
                     out_valid, out_data[99:96], out_data[95:64], out_data[63:0]);
        end
        idle(1);
        @(negedge clk);
        checks++;
        if (out_data[99:96] !== 4'd0 || out_data[63:0] !== 64'h80000014) begin
            errors++;
            $display("FAIL mixed_second: got skip=%0d pc=%h expected 0/80000014", out_data[99:96], out_data[63:0]);
        end
        idle(2);
    endtask

    task automatic test_saturation;
        repeat (20) drive(1, 1, 64'h200, 32'h13);
        drive(1, 0, 64'h300, 32'h6f);
        idle(1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data[99:96] !== 4'd15) begin
            errors++;
            $display("FAIL saturation: got v=%b skip=%0d expected 1/15", out_valid, out_data[99:96]);
        end
        idle(2);
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 64'h1000 + 64'(i * 4), 32'(i));
            out_ready = 0;
        end
        idle(1);
        @(negedge clk);
        checks++;
        if (level !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill: got lvl=%0d ovf=%b expected 16/0", level, overflow);
        end
        drive(1, 0, 64'h1040, 32'h10);
        idle(1);
        @(negedge clk);
        checks++;
        if (level !== 5'd16 || overflow !== 1'b1 || lost_count !== 16'd1) begin
            errors++;
            $display("FAIL first_loss: got lvl=%0d ovf=%b lost=%0d expected 16/1/1", level, overflow, lost_count);
        end
        checks++;
        if (out_data[63:0] !== 64'h1000) begin
            errors++;
            $display("FAIL held_head: got %h expected 1000", out_data[63:0]);
        end
        drive(1, 0, 64'h2000, 32'haa);
        out_ready = 1;
        drive(0, 0, '0, '0);
        out_ready = 0;
        @(negedge clk);
        checks++;
        if (level !== 5'd16 || lost_count !== 16'd1 || out_data[63:0] !== 64'h1004) begin
            errors++;
            $display("FAIL full_pop: got lvl=%0d lost=%0d head=%h expected 16/1/1004", level, lost_count, out_data[63:0]);
        end
        drive(1, 0, 64'h3000, 32'hbb);
        overflow_clr = 1;
        idle(1);
        overflow_clr = 0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || lost_count !== 16'd1) begin
            errors++;
            $display("FAIL clr_vs_loss: got ovf=%b lost=%0d expected 1/1", overflow, lost_count);
        end
        drive(0, 0, '0, '0);
        overflow_clr = 1;
        idle(1);
        overflow_clr = 0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || lost_count !== 16'd0) begin
            errors++;
            $display("FAIL clear: got ovf=%b lost=%0d expected 0/0", overflow, lost_count);
        end
        drive(0, 0, '0, '0);
        out_ready = 1;
        idle(17);
        @(negedge clk);
        checks++;
        if (level !== 5'd0 || m_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got lvl=%0d pending=%0d expected 0/0", level, m_q.size());
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 64'h5000 + 64'(i * 4), 32'h63);
            out_ready = 0;
        end
        repeat (7) drive(1, 1, 64'h5100, 32'h13);
        idle(1);
        @(negedge clk);
        checks++;
        if (level !== 5'd5) begin
            errors++;
            $display("FAIL pre_reset_level: got %0d expected 5", level);
        end
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b lvl=%0d expected 0/0", out_valid, level);
        end
        drive(0, 0, '0, '0);
        rst = 0;
        out_ready = 1;
        drive(1, 0, 64'h4000, 32'h6f);
        idle(1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data[99:96] !== 4'd0 || out_data[63:0] !== 64'h4000) begin
            errors++;
            $display("FAIL post_reset_skip: got v=%b skip=%0d pc=%h expected 1/0/4000", out_valid, out_data[99:96], out_data[63:0]);
        end
        idle(2);
    endtask

`ifdef TRACE_PACKER_TIMESTAMP_EN
    task automatic test_timestamp;
        logic [31:0] ts_a;
        drive(1, 0, 64'h6000, 32'h63);
        out_ready = 0;
        idle(3);
        drive(1, 0, 64'h6004, 32'h63);
        idle(1);
        @(negedge clk);
        ts_a = out_data[131:100];
        drive(0, 0, '0, '0);
        out_ready = 1;
        drive(0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (out_data[131:100] - ts_a !== 32'd4) begin
            errors++;
            $display("FAIL timestamp_delta: got %0d expected 4", out_data[131:100] - ts_a);
        end
        idle(2);
    endtask
`endif

    initial begin
        test_reset;
        test_mixed;
        test_saturation;
        test_backpressure;
        test_reset_mid;
`ifdef TRACE_PACKER_TIMESTAMP_EN
        test_timestamp;
`endif
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
